// File: rtl/game_tick_scheduler_pkg.sv
// Shared definitions for the game tick scheduler: state encoding, default
// timing parameters and the ball period helper.
package game_tick_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_PAUSED = 2'd3
  } state_t;

  localparam int DEF_TICK_DIV         = 50000;
  localparam int DEF_BALL_PERIOD_INIT = 20;
  localparam int DEF_BALL_PERIOD_MIN  = 5;
  localparam int DEF_SPEED_STEP       = 1;
  localparam int DEF_PADDLE_PERIOD    = 10;
  localparam int DEF_SERVE_DELAY      = 1000;

  localparam int CNT_W = 16;

  // Ball period in ms ticks; the subtraction is guarded so it never wraps.
  function automatic logic [CNT_W-1:0] calc_ball_period(
    input int unsigned init_p,
    input int unsigned min_p,
    input int unsigned step_p,
    input logic [3:0]  level
  );
    int unsigned dec;
    dec = int'(level) * step_p;
    if (dec >= init_p || (init_p - dec) < min_p)
      return CNT_W'(min_p);
    else
      return CNT_W'(init_p - dec);
  endfunction

endpackage

// File: rtl/game_tick_scheduler_tick_prescaler.sv
// Free-running divider: one registered tick every TICK_DIV clk cycles,
// running regardless of game state.
module tick_prescaler
  import game_tick_scheduler_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          tick_reg;

  always_comb begin
    cnt_next = (cnt_reg == CW'(TICK_DIV - 1)) ? '0 : cnt_reg + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      tick_reg <= (cnt_next == CW'(TICK_DIV - 1));
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/game_tick_scheduler.sv
// Game timing FSM: serve delay, ball and paddle step pulses, speed levels
// and pause handling on top of the shared 1 ms prescaler.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int TICK_DIV         = DEF_TICK_DIV,
  parameter int BALL_PERIOD_INIT = DEF_BALL_PERIOD_INIT,
  parameter int BALL_PERIOD_MIN  = DEF_BALL_PERIOD_MIN,
  parameter int SPEED_STEP       = DEF_SPEED_STEP,
  parameter int PADDLE_PERIOD    = DEF_PADDLE_PERIOD,
  parameter int SERVE_DELAY      = DEF_SERVE_DELAY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic       score,
  output logic       ms_tick,
  output logic       ball_step,
  output logic       paddle_step,
  output logic [1:0] state,
  output logic [3:0] speed_level
);

  logic tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_t           state_reg, state_next;
  state_t           ret_reg, ret_next;
  logic [3:0]       speed_reg, speed_next;
  logic [CNT_W-1:0] serve_cnt_reg, serve_cnt_next;
  logic [CNT_W-1:0] ball_cnt_reg, ball_cnt_next;
  logic [CNT_W-1:0] paddle_cnt_reg, paddle_cnt_next;
  logic             ms_tick_reg;
  logic             ball_step_reg, ball_step_next;
  logic             paddle_step_reg, paddle_step_next;

  logic [CNT_W-1:0] ball_period;
  logic             serve_last, ball_last, paddle_last;

  // >= rather than == so a counter left beyond a freshly shortened period
  // still fires on the next tick.
  always_comb begin
    ball_period = calc_ball_period(BALL_PERIOD_INIT, BALL_PERIOD_MIN, SPEED_STEP, speed_reg);
    serve_last  = (serve_cnt_reg  >= CNT_W'(SERVE_DELAY - 1));
    ball_last   = (ball_cnt_reg   >= ball_period - CNT_W'(1));
    paddle_last = (paddle_cnt_reg >= CNT_W'(PADDLE_PERIOD - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      ret_reg         <= ST_IDLE;
      speed_reg       <= '0;
      serve_cnt_reg   <= '0;
      ball_cnt_reg    <= '0;
      paddle_cnt_reg  <= '0;
      ms_tick_reg     <= 1'b0;
      ball_step_reg   <= 1'b0;
      paddle_step_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ret_reg         <= ret_next;
      speed_reg       <= speed_next;
      serve_cnt_reg   <= serve_cnt_next;
      ball_cnt_reg    <= ball_cnt_next;
      paddle_cnt_reg  <= paddle_cnt_next;
      ms_tick_reg     <= tick;
      ball_step_reg   <= ball_step_next;
      paddle_step_reg <= paddle_step_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ret_next   = ret_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_SERVE;
      end
      ST_SERVE: begin
        if (pause) begin
          state_next = ST_PAUSED;
          ret_next   = ST_SERVE;
        end else if (tick && serve_last) begin
          state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (score) begin
          state_next = ST_SERVE;
        end else if (pause) begin
          state_next = ST_PAUSED;
          ret_next   = ST_PLAY;
        end
      end
      ST_PAUSED: begin
        if (!pause) state_next = ret_reg;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Steps are decided on the edge the prescaler tick is high, so they land
  // in the same cycle as the delayed ms_tick output.
  always_comb begin
    speed_next       = speed_reg;
    serve_cnt_next   = serve_cnt_reg;
    ball_cnt_next    = ball_cnt_reg;
    paddle_cnt_next  = paddle_cnt_reg;
    ball_step_next   = 1'b0;
    paddle_step_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          serve_cnt_next  = '0;
          ball_cnt_next   = '0;
          paddle_cnt_next = '0;
        end
      end
      ST_SERVE: begin
        if (!pause && tick) begin
          if (serve_last) begin
            serve_cnt_next  = '0;
            ball_cnt_next   = '0;
            paddle_cnt_next = '0;
          end else begin
            serve_cnt_next = serve_cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (score) begin
          speed_next      = '0;
          serve_cnt_next  = '0;
          ball_cnt_next   = '0;
          paddle_cnt_next = '0;
        end else if (!pause) begin
          if (hit && speed_reg != 4'd15) speed_next = speed_reg + 4'd1;
          if (tick) begin
            if (ball_last) begin
              ball_step_next = 1'b1;
              ball_cnt_next  = '0;
            end else begin
              ball_cnt_next = ball_cnt_reg + CNT_W'(1);
            end
            if (paddle_last) begin
              paddle_step_next = 1'b1;
              paddle_cnt_next  = '0;
            end else begin
              paddle_cnt_next = paddle_cnt_reg + CNT_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign ms_tick     = ms_tick_reg;
  assign ball_step   = ball_step_reg;
  assign paddle_step = paddle_step_reg;
  assign state       = state_reg;
  assign speed_level = speed_reg;

endmodule
